nn_infer_ctrl: RTL and testbench
================================

NN_INFER_CTRL -- requirements
Module: nn_infer_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset. The ports SHALL be as follows, clock and reset first:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input vector offered
- in_vec  in  6  binary sensor inputs; bit0 = input 1
- in_ready  out  1  block can accept a vector
- out_valid  out  1  move result held
- out_ready  in  1  consumer takes the result
- move  out  2  result: 0, 1 or 2
- busy  out  1  inference in progress
- wr_en  in  1  weight write strobe
- wr_addr  in  7  weight address
- wr_data  in  12  signed two's-complement weight
- wr_drop  out  1  one-cycle pulse when a write is rejected

Function
REQ-002 Weight RAM SHALL hold 73 signed 12-bit entries:
- Hidden node n (0..6): addresses n*7+0..5 are input weights; address n*7+6 is the bias.
- Output node m (0..2): addresses 49+m*8+0..6 are hidden weights; address 49+m*8+7 is the bias.
REQ-003 A write with wr_en=1, busy=0 and wr_addr<73 SHALL update the entry at the clock edge.
REQ-004 wr_addr>=73 SHALL be ignored silently.
REQ-005 wr_en=1 while busy=1 SHALL be dropped, and wr_drop SHALL be 1 the next cycle.
REQ-006 The FSM states SHALL be IDLE, HID, OUT, ARG and DONE.
REQ-007 in_ready SHALL be 1 only in IDLE.
REQ-008 busy SHALL be 1 in HID, OUT and ARG.
REQ-009 In IDLE, in_valid=1 SHALL latch in_vec, clear the accumulator and enter HID with node=0, step=0.
REQ-010 HID SHALL take one cycle per step, 7 steps per node, 49 cycles in total:
- Steps 0..5: add weight[n*7+step] when in_vec[step]=1, else add 0.
- Step 6: add the bias, apply ReLU with saturation, store h[n] and clear the accumulator.
REQ-011 The hidden accumulator SHALL be signed 16-bit; ReLU SHALL map <0 to 0 and >4095 to 4095, giving unsigned 12-bit h[n].
REQ-012 OUT SHALL take 8 steps per node, 24 cycles in total:
- Steps 0..6: acc += h[step] * weight (signed 28-bit accumulator).
- Step 7: add the bias, store score[m] = acc<0 ? 0 : acc[25:0].
REQ-013 ARG SHALL last one cycle and set move as follows:
- If s0>s1: move=0 when s0>s2, else 2.
- Otherwise: move=1 when s1>s2, else 2.
- All comparisons are strict, so all-equal scores give move=2.
REQ-014 out_valid SHALL rise exactly 74 cycles after the in_valid&in_ready edge.
REQ-015 move and out_valid SHALL be held in DONE until out_ready=1; that cycle returns to IDLE and out_valid drops the next cycle.
REQ-016 in_valid SHALL be ignored outside IDLE, and in_vec changes after the latch SHALL have no effect.
REQ-017 A wr_en to an entry in the same cycle as the IDLE accept SHALL be dropped with wr_drop.

Reset
REQ-018 While rst_n=0, the block SHALL force: state=IDLE, out_valid=0, move=0, busy=0, wr_drop=0, accumulator=0, h[0..6]=0, score[0..2]=0.
REQ-019 in_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-020 Weight RAM SHALL NOT be reset and SHALL retain its contents across rst_n.
REQ-021 A reset during HID, OUT, ARG or DONE SHALL abort the inference, and no out_valid SHALL follow.

Configuration
REQ-022 With NN_PROBE_EN defined, the block SHALL add these outputs, registered when out_valid rises:
- hid_lvl[27:0]: 4 bits per node n at [4n+3:4n], value min(h[n]/60, 12).
- out_lvl[11:0]: 4 bits per node m at [4m+3:4m], value min(score[m]/240, 12).
- Both SHALL reset to 0.
REQ-023 Without NN_PROBE_EN, these ports and their divider logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-024 The bench SHALL cover these scenarios:
- All weights 0, address 72 (output 2 bias) = 5; any in_vec, accept at T -> out_valid at T+74, move=2; then set address 72=0 and address 64 (output 1 bias)=5 -> move=1.
- All weights 0 -> scores all 0, move=2 (tie rule).
- Addresses 0..6 = 2047, in_vec=6'b111111 -> h[0]=4095 (saturated); with NN_PROBE_EN, hid_lvl[3:0]=12.
- Address 6 = -100, others 0 -> h[0]=0 (ReLU).
- out_ready=0 for 10 cycles after out_valid -> move stable, in_ready=0, second in_valid ignored; out_ready=1 -> in_ready=1 next cycle.
- rst_n pulsed low 20 cycles into HID -> no out_valid, in_ready=1 after release, weights intact; wr_en during busy -> wr_drop=1 one cycle, entry unchanged.

Source files
------------

// File: rtl/nn_infer_ctrl.sv
// -----------------------------------------------------------------------------
// nn_infer_ctrl
//
// Sequential inference engine for a tiny 6-7-3 fully connected network that
// picks one of three moves from six binary sensor inputs. One weight is read
// and accumulated per clock cycle. The hidden layer uses a saturating ReLU and
// the output layer is followed by an argmax.
//
// Timing: the vector is accepted on edge T. Hidden nodes take 49 cycles,
// output nodes take 24 cycles and the argmax takes 1 cycle. out_valid
// therefore rises after edge T+74.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input vector offered (accepted only while in_ready=1)
//   in_vec     6 binary sensor inputs, bit0 = input 1
//   in_ready   high only in IDLE
//   out_valid  move result held until out_ready
//   out_ready  consumer takes the result
//   move       result 0, 1 or 2
//   busy       inference in progress (HID, OUT, ARG)
//   wr_en      weight write strobe
//   wr_addr    weight address 0..72 (higher addresses are ignored)
//   wr_data    signed 12-bit weight
//   wr_drop    one-cycle pulse after a write that was rejected
//
// Weight map
//   hidden n (0..6): n*7+0..5 are input weights, n*7+6 is the bias
//   output m (0..2): 49+m*8+0..6 are hidden weights, 49+m*8+7 is the bias
//
// Optional build macro NN_PROBE_EN adds these outputs:
//   hid_lvl[27:0]  min(h[n]/60, 12) per hidden node, 4 bits each
//   out_lvl[11:0]  min(score[m]/240, 12) per output node, 4 bits each
// Both are captured when out_valid rises.
// -----------------------------------------------------------------------------
module nn_infer_ctrl (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [5:0]         in_vec,
   output logic               in_ready,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [1:0]         move,
   output logic               busy,
   input  logic               wr_en,
   input  logic [6:0]         wr_addr,
   input  logic signed [11:0] wr_data,
   output logic               wr_drop
`ifdef NN_PROBE_EN
   ,
   output logic [27:0]        hid_lvl,
   output logic [11:0]        out_lvl
`endif
);

   localparam int COEF_W  = 12;
   localparam int N_WORDS = 73;

   typedef enum logic [2:0] {IDLE, HID, OUT, ARG, DONE} state_t;

   state_t                    state;
   logic [5:0]                vec;
   logic [2:0]                node;
   logic [2:0]                step;
   logic signed [15:0]        hacc;
   logic signed [27:0]        oacc;
   logic [11:0]               h     [7];
   logic [25:0]               score [3];
   logic signed [COEF_W-1:0]  wram  [N_WORDS];

   logic [6:0]                rd_addr;
   logic signed [COEF_W-1:0]  weight;
   logic signed [15:0]        hterm;
   logic signed [15:0]        hsum;
   logic signed [12:0]        hval;
   logic signed [24:0]        prod;
   logic signed [27:0]        oterm;
   logic signed [27:0]        osum;
   logic                      accept;
   logic                      addr_ok;
   logic                      wr_ok;
   logic                      drop_nxt;

   function automatic logic [11:0] relu_sat(input logic signed [15:0] x);
      if (x < 16'sd0)
         return 12'd0;
      else if (x > 16'sd4095)
         return 12'd4095;
      else
         return x[11:0];
   endfunction

   function automatic logic [25:0] clamp_score(input logic signed [27:0] x);
      return (x < 28'sd0) ? 26'd0 : x[25:0];
   endfunction

   // Strict comparisons: ties fall through to the higher index.
   function automatic logic [1:0] arg_move(input logic [25:0] s0,
                                           input logic [25:0] s1,
                                           input logic [25:0] s2);
      if (s0 > s1)
         return (s0 > s2) ? 2'd0 : 2'd2;
      else
         return (s1 > s2) ? 2'd1 : 2'd2;
   endfunction

`ifdef NN_PROBE_EN
   // The divisor is constant and the result is capped at 12, so a
   // threshold ladder replaces a real divider.
   function automatic logic [3:0] lvl_div(input logic [25:0] x,
                                          input logic [25:0] d);
      logic [3:0]  l;
      logic [29:0] thr;
      l   = 4'd0;
      thr = {4'd0, d};
      for (int k = 1; k <= 12; k++) begin
         if ({4'd0, x} >= thr)
            l = l + 4'd1;
         thr = thr + {4'd0, d};
      end
      return l;
   endfunction
`endif

   // Weight address for the current step. node and step are zero
   // outside HID/OUT, so the address stays in range.
   always_comb begin
      rd_addr = 7'd0;
      if (state == OUT)
         rd_addr = 7'd49 + {1'b0, node, 3'b000} + {4'd0, step};
      else
         rd_addr = ({4'd0, node} * 7'd7) + {4'd0, step};
   end

   assign weight = wram[rd_addr];

   // Hidden step: steps 0..5 add a weight gated by the input bit, step 6 adds the bias.
   assign hterm = ((step == 3'd6) || vec[step]) ? {{4{weight[11]}}, weight} : 16'sd0;
   assign hsum  = hacc + hterm;

   // Output step: h is unsigned, so a zero bit is prepended before the signed multiply.
   assign hval  = {1'b0, h[step]};
   assign prod  = hval * weight;
   assign oterm = (step == 3'd7) ? {{16{weight[11]}}, weight} : {{3{prod[24]}}, prod};
   assign osum  = oacc + oterm;

   assign accept   = (state == IDLE) && in_valid;
   assign addr_ok  = (wr_addr < 7'd73);
   assign wr_ok    = wr_en && !busy && !accept && addr_ok;
   assign drop_nxt = wr_en && (busy || (accept && addr_ok));

   // Weight RAM is not reset, so its contents survive rst_n.
   always_ff @(posedge clk) begin
      if (wr_ok)
         wram[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         move      <= 2'd0;
         wr_drop   <= 1'b0;
         vec       <= 6'd0;
         node      <= 3'd0;
         step      <= 3'd0;
         hacc      <= 16'sd0;
         oacc      <= 28'sd0;
         for (int i = 0; i < 7; i++) h[i] <= 12'd0;
         for (int i = 0; i < 3; i++) score[i] <= 26'd0;
`ifdef NN_PROBE_EN
         hid_lvl   <= 28'd0;
         out_lvl   <= 12'd0;
`endif
      end else begin
         wr_drop <= drop_nxt;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  vec      <= in_vec;
                  hacc     <= 16'sd0;
                  oacc     <= 28'sd0;
                  node     <= 3'd0;
                  step     <= 3'd0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= HID;
               end
            end
            HID: begin
               if (step == 3'd6) begin
                  h[node] <= relu_sat(hsum);
                  hacc    <= 16'sd0;
                  step    <= 3'd0;
                  if (node == 3'd6) begin
                     node  <= 3'd0;
                     state <= OUT;
                  end else begin
                     node <= node + 3'd1;
                  end
               end else begin
                  hacc <= hsum;
                  step <= step + 3'd1;
               end
            end
            OUT: begin
               if (step == 3'd7) begin
                  score[node[1:0]] <= clamp_score(osum);
                  oacc             <= 28'sd0;
                  step             <= 3'd0;
                  if (node == 3'd2) begin
                     node  <= 3'd0;
                     state <= ARG;
                  end else begin
                     node <= node + 3'd1;
                  end
               end else begin
                  oacc <= osum;
                  step <= step + 3'd1;
               end
            end
            ARG: begin
               move      <= arg_move(score[0], score[1], score[2]);
               out_valid <= 1'b1;
               busy      <= 1'b0;
               state     <= DONE;
`ifdef NN_PROBE_EN
               for (int n = 0; n < 7; n++)
                  hid_lvl[4*n +: 4] <= lvl_div({14'd0, h[n]}, 26'd60);
               for (int m = 0; m < 3; m++)
                  out_lvl[4*m +: 4] <= lvl_div(score[m], 26'd240);
`endif
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nn_infer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nn_infer_ctrl
//
// Directed bench for nn_infer_ctrl. Each scenario task loads a small weight
// set and runs inferences. It compares latency and move against results
// worked out by hand from the weight map.
// -----------------------------------------------------------------------------
module tb_nn_infer_ctrl;

   logic               clk;
   logic               rst_n;
   logic               in_valid;
   logic [5:0]         in_vec;
   logic               in_ready;
   logic               out_valid;
   logic               out_ready;
   logic [1:0]         move;
   logic               busy;
   logic               wr_en;
   logic [6:0]         wr_addr;
   logic signed [11:0] wr_data;
   logic               wr_drop;
`ifdef NN_PROBE_EN
   logic [27:0]        hid_lvl;
   logic [11:0]        out_lvl;
`endif

   int checks = 0;
   int errors = 0;

   nn_infer_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_vec    (in_vec),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .move      (move),
      .busy      (busy),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_drop   (wr_drop)
`ifdef NN_PROBE_EN
      ,
      .hid_lvl   (hid_lvl),
      .out_lvl   (out_lvl)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic write_w(input int a, input int d);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = 7'(a);
      wr_data = 12'(d);
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic clear_all();
      for (int a = 0; a < 73; a++) write_w(a, 0);
   endtask

   // Offers v, changes in_vec after the latch, and returns cycles-to-valid.
   task automatic run_inf(input logic [5:0] v, output int lat, output logic [1:0] mv);
      @(negedge clk);
      in_valid = 1'b1;
      in_vec   = v;
      lat      = -1;
      for (int k = 0; k <= 120; k++) begin
         @(negedge clk);
         if (k == 0) begin
            in_valid = 1'b0;
            in_vec   = ~v;
         end
         if (out_valid === 1'b1) begin
            lat = k;
            break;
         end
      end
      mv = move;
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (move !== 2'd0)      begin errors++; $display("FAIL reset_move: got %0d want 0", move); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (wr_drop !== 1'b0)   begin errors++; $display("FAIL reset_wr_drop: got %b want 0", wr_drop); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_tie();
      int lat; logic [1:0] mv;
      clear_all();
      run_inf(6'b101010, lat, mv);
      checks++; if (lat != 74)   begin errors++; $display("FAIL tie_latency: got %0d want 74", lat); end
      checks++; if (mv !== 2'd2) begin errors++; $display("FAIL tie_move: got %0d want 2", mv); end
      release_out();
   endtask

   task automatic test_bias();
      int lat; logic [1:0] mv;
      write_w(72, 5);
      run_inf(6'b110011, lat, mv);
      checks++; if (lat != 74)   begin errors++; $display("FAIL bias2_latency: got %0d want 74", lat); end
      checks++; if (mv !== 2'd2) begin errors++; $display("FAIL bias2_move: got %0d want 2", mv); end
      release_out();
      write_w(72, 0);
      write_w(64, 5);
      run_inf(6'b000001, lat, mv);
      checks++; if (mv !== 2'd1) begin errors++; $display("FAIL bias1_move: got %0d want 1", mv); end
      release_out();
      write_w(64, 0);
      write_w(56, 5);
      run_inf(6'b111111, lat, mv);
      checks++; if (mv !== 2'd0) begin errors++; $display("FAIL bias0_move: got %0d want 0", mv); end
      release_out();
      write_w(56, 0);
   endtask

   // h0 saturates to 4095. h1 = 2047+w8+2047 is the reference: s0=h0, s1=h1.
   task automatic test_saturate();
      int lat; logic [1:0] mv;
      clear_all();
      for (int a = 0; a < 7; a++) write_w(a, 2047);
      write_w(7, 2047);
      write_w(8, 1);
      write_w(13, 2047);
      write_w(49, 1);
      write_w(58, 1);
      run_inf(6'b111111, lat, mv);
      checks++; if (lat != 74)   begin errors++; $display("FAIL sat_latency: got %0d want 74", lat); end
      checks++; if (mv !== 2'd1) begin errors++; $display("FAIL sat_eq_4095: got move %0d want 1", mv); end
`ifdef NN_PROBE_EN
      checks++; if (hid_lvl[3:0] !== 4'd12) begin errors++; $display("FAIL sat_hid_lvl: got %0d want 12", hid_lvl[3:0]); end
`endif
      release_out();
      write_w(8, 0);
      run_inf(6'b111111, lat, mv);
      checks++; if (mv !== 2'd0) begin errors++; $display("FAIL sat_gt_4094: got move %0d want 0", mv); end
      release_out();
   endtask

   task automatic test_relu();
      int lat; logic [1:0] mv;
      clear_all();
      write_w(6, -100);
      write_w(49, 1);
      write_w(72, 1);
      run_inf(6'b010101, lat, mv);
      checks++; if (mv !== 2'd2) begin errors++; $display("FAIL relu_hidden: got move %0d want 2", mv); end
      release_out();
      write_w(72, 0);
      write_w(64, -50);
      run_inf(6'b010101, lat, mv);
      checks++; if (mv !== 2'd2) begin errors++; $display("FAIL relu_score: got move %0d want 2", mv); end
      release_out();
   endtask

   task automatic test_inputs();
      int lat; logic [1:0] mv;
      clear_all();
      write_w(9, 100);
      write_w(58, 1);
      write_w(72, 1);
      run_inf(6'b111011, lat, mv);
      checks++; if (mv !== 2'd2) begin errors++; $display("FAIL input_bit_clear: got move %0d want 2", mv); end
      release_out();
      run_inf(6'b000100, lat, mv);
      checks++; if (mv !== 2'd1) begin errors++; $display("FAIL input_bit_set: got move %0d want 1", mv); end
      release_out();
      write_w(58, 0);
      write_w(50, -3);
      write_w(56, 400);
      write_w(72, 101);
      run_inf(6'b000100, lat, mv);
      checks++; if (mv !== 2'd2) begin errors++; $display("FAIL signed_mul_lo: got move %0d want 2", mv); end
      release_out();
      write_w(72, 99);
      run_inf(6'b000100, lat, mv);
      checks++; if (mv !== 2'd0) begin errors++; $display("FAIL signed_mul_hi: got move %0d want 0", mv); end
      release_out();
   endtask

   task automatic test_hold();
      int lat; logic [1:0] mv;
      run_inf(6'b000100, lat, mv);
      checks++; if (lat != 74)   begin errors++; $display("FAIL hold_latency: got %0d want 74", lat); end
      checks++; if (mv !== 2'd0) begin errors++; $display("FAIL hold_move: got %0d want 0", mv); end
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         @(negedge clk);
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b want 1", i, out_valid); end
         checks++; if (move !== 2'd0)      begin errors++; $display("FAIL hold_stable[%0d]: got %0d want 0", i, move); end
         checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready); end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_drop: got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL hold_return: got %b want 1", in_ready); end
      @(negedge clk);
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL hold_ignored: got in_ready %b want 1", in_ready); end
   endtask

   task automatic test_reset_abort();
      int lat; logic [1:0] mv; bit seen;
      @(negedge clk);
      in_valid = 1'b1;
      in_vec   = 6'b000100;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (20) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b want 1", busy); end
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL abort_rst_busy: got %b want 0", busy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_rst_ready: got %b want 1", in_ready); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b want 1", in_ready); end
      seen = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      checks++; if (seen) begin errors++; $display("FAIL abort_no_valid: got out_valid 1 want 0"); end
      run_inf(6'b000100, lat, mv);
      checks++; if (lat != 74)   begin errors++; $display("FAIL abort_rerun_latency: got %0d want 74", lat); end
      checks++; if (mv !== 2'd0) begin errors++; $display("FAIL abort_weights: got move %0d want 0", mv); end
      release_out();
   endtask

   task automatic test_wr_drop();
      int lat; logic [1:0] mv;
      @(negedge clk);
      in_valid = 1'b1;
      in_vec   = 6'b000100;
      wr_en    = 1'b1;
      wr_addr  = 7'd56;
      wr_data  = 12'sd0;
      @(negedge clk);
      in_valid = 1'b0;
      wr_en    = 1'b0;
      checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL drop_accept: got %b want 1", wr_drop); end
      @(negedge clk);
      checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL drop_accept_pulse: got %b want 0", wr_drop); end
      repeat (3) @(negedge clk);
      wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL drop_busy: got %b want 1", wr_drop); end
      @(negedge clk);
      checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL drop_busy_pulse: got %b want 0", wr_drop); end
      lat = -1;
      for (int k = 0; k < 120; k++) begin
         if (out_valid === 1'b1) begin lat = k; break; end
         @(negedge clk);
      end
      checks++; if (lat < 0)          begin errors++; $display("FAIL drop_timeout: got no out_valid want out_valid"); end
      checks++; if (move !== 2'd0)    begin errors++; $display("FAIL drop_unchanged: got move %0d want 0", move); end
      release_out();
      write_w(100, 5);
      checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL drop_high_addr: got %b want 0", wr_drop); end
      write_w(56, 0);
      run_inf(6'b000100, lat, mv);
      checks++; if (mv !== 2'd2)      begin errors++; $display("FAIL write_idle: got move %0d want 2", mv); end
      release_out();
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_vec    = 6'd0;
      out_ready = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = 7'd0;
      wr_data   = 12'sd0;
      test_reset();
      test_tie();
      test_bias();
      test_saturate();
      test_relu();
      test_inputs();
      test_hold();
      test_reset_abort();
      test_wr_drop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
